// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions for the HI/LO sequencer
package cpu_defs;

  // Bit positions inside the one-hot hilo op vector
  localparam int HILO_OP_W   = 4;
  localparam int HILO_DIV    = 0;
  localparam int HILO_DIVU   = 1;
  localparam int HILO_MULT   = 2;
  localparam int HILO_MULTU  = 3;

  // Default multiplier pipeline depth
  localparam int DEFAULT_MUL_LAT = 2;

  typedef enum logic [2:0] {
    HS_IDLE,
    HS_MUL,
    HS_DIV_ISSUE,
    HS_DIV_WAIT,
    HS_DRAIN
  } hilo_seq_state_t;

endpackage

// File: rtl/hilo_seq_ctrl_if.sv
// rtl/hilo_seq_ctrl_if.sv - EXE request, multiplier, divider and HI/LO write bundle
interface hilo_seq_ctrl_if;

  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        req_ready;
  logic        busy;
  logic        flush;
  logic        commit_block;

  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;

  logic        div_tvalid;
  logic        divu_tvalid;
  logic        div_tready;
  logic        divu_tready;
  logic [31:0] div_tdata_a;
  logic [31:0] div_tdata_b;
  logic        div_dout_tvalid;
  logic        divu_dout_tvalid;
  logic [63:0] div_dout;
  logic [63:0] divu_dout;

  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush, commit_block,
    input  mul_p,
    input  div_tready, divu_tready, div_dout_tvalid, divu_dout_tvalid, div_dout, divu_dout,
    output req_ready, busy,
    output mul_a, mul_b,
    output div_tvalid, divu_tvalid, div_tdata_a, div_tdata_b,
    output hi_we, lo_we, hi_wdata, lo_wdata
  );

  // EXE stage plus arithmetic units side
  modport master (
    output req_valid, req_op, req_src1, req_src2, flush, commit_block,
    output mul_p,
    output div_tready, divu_tready, div_dout_tvalid, divu_dout_tvalid, div_dout, divu_dout,
    input  req_ready, busy,
    input  mul_a, mul_b,
    input  div_tvalid, divu_tvalid, div_tdata_a, div_tdata_b,
    input  hi_we, lo_we, hi_wdata, lo_wdata
  );

endinterface

// File: rtl/hilo_seq_ctrl_mul_sign_fix.sv
// rtl/hilo_seq_ctrl_mul_sign_fix.sv - signed multiply via unsigned core: operand abs and product negate
module mul_sign_fix (
  input  logic        is_mult,
  input  logic        neg,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [63:0] prod,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] res;

  // -0x80000000 wraps to itself, which is the correct magnitude for an unsigned core
  assign mul_a  = (is_mult && src1[31]) ? (32'd0 - src1) : src1;
  assign mul_b  = (is_mult && src2[31]) ? (32'd0 - src2) : src2;
  assign res    = neg ? (64'd0 - prod) : prod;
  assign res_hi = res[63:32];
  assign res_lo = res[31:0];

endmodule

// File: rtl/hilo_seq_ctrl.sv
// rtl/hilo_seq_ctrl.sv - HI/LO multiply/divide sequencer between EXE and the arithmetic units
module hilo_seq_ctrl
  import cpu_defs::*;
#(
  parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
  input logic            clk,
  input logic            reset,
  hilo_seq_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  hilo_seq_state_t  state;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             is_divu;
  logic             busy_q;

  logic        op_valid, op_div, op_divu, op_mult, op_multu;
  logic        accept, bad_op;
  logic        div_tvalid_c, divu_tvalid_c, tready_hit;
  logic        dout_sel_valid;
  logic [63:0] dout_sel;
  logic        mul_done, div_done, done, wr;
  logic [31:0] mul_hi, mul_lo;

  assign op_valid = $onehot(bus.req_op);
  assign op_div   = op_valid & bus.req_op[HILO_DIV];
  assign op_divu  = op_valid & bus.req_op[HILO_DIVU];
  assign op_mult  = op_valid & bus.req_op[HILO_MULT];
  assign op_multu = op_valid & bus.req_op[HILO_MULTU];

  // New ops are only taken from IDLE; a malformed op is retired on the spot
  assign accept = (state == HS_IDLE) & bus.req_valid & ~bus.flush & ~reset;
  assign bad_op = accept & ~op_valid;

  // Operands are presented from IDLE and held until the selected divider takes them
  assign div_tvalid_c  = (accept & op_div) |
                         ((state == HS_DIV_ISSUE) & ~is_divu & ~bus.flush & ~reset);
  assign divu_tvalid_c = (accept & op_divu) |
                         ((state == HS_DIV_ISSUE) & is_divu & ~bus.flush & ~reset);
  assign tready_hit    = (div_tvalid_c & bus.div_tready) | (divu_tvalid_c & bus.divu_tready);

  assign bus.div_tvalid  = div_tvalid_c;
  assign bus.divu_tvalid = divu_tvalid_c;
  assign bus.div_tdata_a = (div_tvalid_c | divu_tvalid_c) ? bus.req_src1 : 32'd0;
  assign bus.div_tdata_b = (div_tvalid_c | divu_tvalid_c) ? bus.req_src2 : 32'd0;

  assign dout_sel_valid = is_divu ? bus.divu_dout_tvalid : bus.div_dout_tvalid;
  assign dout_sel       = is_divu ? bus.divu_dout : bus.div_dout;

  mul_sign_fix u_sign_fix (
    .is_mult (op_mult),
    .neg     (neg),
    .src1    (bus.req_src1),
    .src2    (bus.req_src2),
    .prod    (bus.mul_p),
    .mul_a   (bus.mul_a),
    .mul_b   (bus.mul_b),
    .res_hi  (mul_hi),
    .res_lo  (mul_lo)
  );

  assign mul_done = (state == HS_MUL) & (cnt == CNT_W'(MUL_LAT));
  assign div_done = (state == HS_DIV_WAIT) & dout_sel_valid;
  assign done     = (mul_done | div_done) & ~reset;
  assign wr       = done & ~bus.flush & ~bus.commit_block;

  assign bus.req_ready = (done & ~bus.flush) | bad_op;
  assign bus.busy      = busy_q;
  assign bus.hi_we     = wr;
  assign bus.lo_we     = wr;
  // Divider packs quotient high, remainder low; HI takes the remainder
  assign bus.hi_wdata  = wr ? (mul_done ? mul_hi : dout_sel[31:0])  : 32'd0;
  assign bus.lo_wdata  = wr ? (mul_done ? mul_lo : dout_sel[63:32]) : 32'd0;

  // Sequencer FSM: one op in flight, divides already accepted by a divider are drained
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HS_IDLE;
      cnt     <= '0;
      neg     <= 1'b0;
      is_divu <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (accept && op_valid) begin
            busy_q <= 1'b1;
            if (op_mult || op_multu) begin
              state <= HS_MUL;
              cnt   <= CNT_W'(1);
              neg   <= op_mult & (bus.req_src1[31] ^ bus.req_src2[31]);
            end else begin
              is_divu <= op_divu;
              state   <= tready_hit ? HS_DIV_WAIT : HS_DIV_ISSUE;
            end
          end
        end
        HS_MUL: begin
          if (bus.flush || mul_done) begin
            state  <= HS_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HS_DIV_ISSUE: begin
          if (bus.flush) begin
            state  <= HS_IDLE;
            busy_q <= 1'b0;
          end else if (tready_hit) begin
            state <= HS_DIV_WAIT;
          end
        end
        HS_DIV_WAIT: begin
          if (dout_sel_valid) begin
            state  <= HS_IDLE;
            busy_q <= 1'b0;
          end else if (bus.flush) begin
            state <= HS_DRAIN;
          end
        end
        HS_DRAIN: begin
          if (dout_sel_valid) begin
            state  <= HS_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= HS_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// tb/tb_hilo_seq_ctrl.sv - scoreboard bench for the HI/LO sequencer
module tb_hilo_seq_ctrl;

  localparam int MUL_LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hilo_seq_ctrl_if bif();

  hilo_seq_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Unsigned pipelined multiplier model
  logic [63:0] mul_pipe [MUL_LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= {32'd0, bif.mul_a} * {32'd0, bif.mul_b};
    for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign bif.mul_p = mul_pipe[MUL_LAT-1];

  // Every HI/LO write must match the head of the scoreboard
  always @(negedge clk) begin
    if (bif.hi_we || bif.lo_we) begin
      if (sb_q.size() == 0) begin
        check_eq("write_when_sb_empty", {62'd0, bif.hi_we, bif.lo_we}, 64'd0);
      end else begin
        check_eq("hilo_data", {bif.hi_wdata, bif.lo_wdata}, sb_q.pop_front());
        check_eq("we_pair", {62'd0, bif.hi_we, bif.lo_we}, 64'd3);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input logic cb, input logic fl, input string tag);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = (op[2] && a[31]) ? (32'd0 - a) : a;
    eb = (op[2] && b[31]) ? (32'd0 - b) : b;
    bif.req_valid = 1'b1;
    bif.req_op    = op;
    bif.req_src1  = a;
    bif.req_src2  = b;
    if (!cb && !fl) sb_q.push_back(exp_p);
    mid();
    check_eq({tag, "_mul_a"}, bif.mul_a, ea);
    check_eq({tag, "_mul_b"}, bif.mul_b, eb);
    check_eq({tag, "_rdy_accept"}, bif.req_ready, 0);
    for (int i = 1; i < MUL_LAT; i++) begin
      cyc();
      mid();
      check_eq({tag, "_busy"}, bif.busy, 1);
      check_eq({tag, "_rdy_early"}, bif.req_ready, 0);
    end
    cyc();
    bif.commit_block = cb;
    bif.flush        = fl;
    mid();
    check_eq({tag, "_rdy_done"}, bif.req_ready, !fl);
    check_eq({tag, "_hi_we"}, bif.hi_we, !(cb || fl));
    check_eq({tag, "_lo_we"}, bif.lo_we, !(cb || fl));
    cyc();
    bif.req_valid    = 1'b0;
    bif.commit_block = 1'b0;
    bif.flush        = 1'b0;
    mid();
    check_eq({tag, "_busy_after"}, bif.busy, 0);
  endtask

  initial begin
    logic signed [31:0] sa;
    logic signed [31:0] sd;
    logic signed [31:0] q;
    logic signed [31:0] r;

    bif.req_valid = 1'b0;
    bif.req_op = 4'd0;
    bif.req_src1 = 32'd0;
    bif.req_src2 = 32'd0;
    bif.flush = 1'b0;
    bif.commit_block = 1'b0;
    bif.div_tready = 1'b0;
    bif.divu_tready = 1'b0;
    bif.div_dout_tvalid = 1'b0;
    bif.divu_dout_tvalid = 1'b0;
    bif.div_dout = 64'd0;
    bif.divu_dout = 64'd0;

    // Reset state
    cyc(); cyc();
    mid();
    check_eq("rst_busy", bif.busy, 0);
    check_eq("rst_ready", bif.req_ready, 0);
    check_eq("rst_hi_we", bif.hi_we, 0);
    check_eq("rst_div_tvalid", bif.div_tvalid, 0);
    check_eq("rst_hi_wdata", bif.hi_wdata, 0);
    cyc();
    reset = 1'b0;

    // Multiply cases
    cyc(); do_mul(4'b0100, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 1'b0, "mult_neg");
    cyc(); do_mul(4'b1000, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 1'b0, 1'b0, "multu");
    cyc(); do_mul(4'b0100, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 1'b0, "mult_min");
    cyc(); do_mul(4'b0100, 32'hFFFFFFFE, 32'hFFFFFFFE, 64'd4, 1'b1, 1'b0, "mult_cb");
    cyc(); do_mul(4'b0100, 32'd7, 32'hFFFFFFFF, 64'd0, 1'b0, 1'b1, "mult_flush_done");

    // DIV -7/2 with tready held off three cycles
    cyc();
    bif.req_valid = 1'b1; bif.req_op = 4'b0001;
    bif.req_src1 = 32'hFFFFFFF9; bif.req_src2 = 32'd2; bif.div_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_eq("div_tvalid_hold", bif.div_tvalid, 1);
      check_eq("divu_tvalid_quiet", bif.divu_tvalid, 0);
      cyc();
    end
    bif.div_tready = 1'b1;
    mid();
    check_eq("div_tvalid_acc", bif.div_tvalid, 1);
    check_eq("div_tdata_a", bif.div_tdata_a, 32'hFFFFFFF9);
    check_eq("div_tdata_b", bif.div_tdata_b, 32'd2);
    cyc();
    bif.div_tready = 1'b0;
    mid();
    check_eq("div_wait_tvalid", bif.div_tvalid, 0);
    check_eq("div_wait_ready", bif.req_ready, 0);
    check_eq("div_wait_busy", bif.busy, 1);
    cyc();
    sa = -32'sd7; sd = 32'sd2;
    q = sa / sd; r = sa % sd;
    bif.div_dout_tvalid = 1'b1;
    bif.div_dout = {q, r};
    sb_q.push_back({r, q});
    mid();
    check_eq("div_done_ready", bif.req_ready, 1);
    cyc();
    bif.div_dout_tvalid = 1'b0; bif.req_valid = 1'b0;
    mid();
    check_eq("div_strobe_1cyc", bif.hi_we, 0);
    check_eq("div_busy_after", bif.busy, 0);

    // DIVU flushed in DIV_WAIT drains, then the next op goes straight in
    cyc();
    bif.req_valid = 1'b1; bif.req_op = 4'b0010;
    bif.req_src1 = 32'd100; bif.req_src2 = 32'd7; bif.divu_tready = 1'b1;
    mid();
    check_eq("divu_tvalid", bif.divu_tvalid, 1);
    check_eq("divu_not_div", bif.div_tvalid, 0);
    cyc();
    bif.divu_tready = 1'b0; bif.flush = 1'b1;
    mid();
    check_eq("divu_flush_ready", bif.req_ready, 0);
    check_eq("divu_flush_tvalid", bif.divu_tvalid, 0);
    cyc();
    bif.flush = 1'b0; bif.req_op = 4'b0100; bif.req_src1 = 32'd6; bif.req_src2 = 32'd7;
    mid();
    check_eq("drain_busy", bif.busy, 1);
    check_eq("drain_ready", bif.req_ready, 0);
    check_eq("drain_no_issue", bif.div_tvalid, 0);
    cyc();
    bif.divu_dout_tvalid = 1'b1; bif.divu_dout = {32'd14, 32'd2};
    mid();
    check_eq("drain_done_ready", bif.req_ready, 0);
    check_eq("drain_done_we", bif.hi_we, 0);
    cyc();
    bif.divu_dout_tvalid = 1'b0;
    do_mul(4'b0100, 32'd6, 32'd7, 64'd42, 1'b0, 1'b0, "post_drain");

    // Flush while still presenting to the divider
    cyc();
    bif.req_valid = 1'b1; bif.req_op = 4'b0001;
    bif.req_src1 = 32'd10; bif.req_src2 = 32'd3; bif.div_tready = 1'b0;
    mid();
    check_eq("issue_tvalid", bif.div_tvalid, 1);
    cyc();
    bif.flush = 1'b1; bif.div_tready = 1'b1;
    mid();
    check_eq("issue_flush_tvalid", bif.div_tvalid, 0);
    check_eq("issue_flush_ready", bif.req_ready, 0);
    cyc();
    bif.flush = 1'b0; bif.req_valid = 1'b0; bif.div_tready = 1'b0;
    mid();
    check_eq("issue_flush_busy", bif.busy, 0);

    // Malformed ops retire immediately
    cyc();
    bif.req_valid = 1'b1; bif.req_op = 4'b0011;
    mid();
    check_eq("bad_op_ready", bif.req_ready, 1);
    check_eq("bad_op_tvalid", bif.div_tvalid, 0);
    check_eq("bad_op_we", bif.hi_we, 0);
    cyc();
    bif.req_op = 4'b0000;
    mid();
    check_eq("zero_op_ready", bif.req_ready, 1);
    cyc();
    bif.req_valid = 1'b0;
    mid();
    check_eq("bad_op_busy", bif.busy, 0);

    // Reset in MUL with cnt=1
    cyc();
    bif.req_valid = 1'b1; bif.req_op = 4'b0100; bif.req_src1 = 32'd3; bif.req_src2 = 32'd3;
    mid();
    check_eq("rst_mul_accept_busy", bif.busy, 0);
    cyc();
    reset = 1'b1;
    mid();
    check_eq("rst_mul_we", bif.hi_we, 0);
    cyc();
    reset = 1'b0; bif.req_valid = 1'b0;
    mid();
    check_eq("rst_mul_busy", bif.busy, 0);
    check_eq("rst_mul_we2", bif.hi_we, 0);
    cyc();
    mid();
    check_eq("rst_mul_we3", bif.lo_we, 0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
